// File: rtl/classifier_pkg.sv
// Shared constants and bank-state encoding for the classifier input path.
package classifier_pkg;
  localparam int CLS_PIXELS = 784;
  localparam int CLS_PIX_W  = 8;
  localparam int CLS_ADDR_W = 10;
  localparam int CLS_RD_W   = 16;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;
endpackage

// File: rtl/frame_bank_ram.sv
// One frame bank: simple dual-port RAM, one write port, one registered read port.
module frame_bank_ram
  import classifier_pkg::*;
#(
  parameter int PIXELS = CLS_PIXELS,
  parameter int PIX_W  = CLS_PIX_W,
  parameter int ADDR_W = CLS_ADDR_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data_p1
);
  logic [PIX_W-1:0] mem [PIXELS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data_p1 <= mem[rd_addr];
  end
endmodule

// File: rtl/classifier_frame_loader.sv
// Ping-pong frame loader: buffers whole frames from a pixel stream and exposes them
// to the classifier through its input-valid register and 1-cycle image read port.
module classifier_frame_loader
  import classifier_pkg::*;
#(
  parameter int PIXELS = CLS_PIXELS,
  parameter int PIX_W  = CLS_PIX_W,
  parameter int ADDR_W = CLS_ADDR_W,
  parameter int RD_W   = CLS_RD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              pix_valid,
  input  logic              pix_last,
  output logic              pix_ready,
  output logic [7:0]        classifier_input_valid_read_data,
  input  logic              classifier_input_valid_write_en,
  input  logic [7:0]        classifier_input_valid_write_data,
  input  logic [ADDR_W-1:0] classifier_input_address_a,
  output logic [RD_W-1:0]   classifier_input_read_data_a,
  output logic              frame_err,
  output logic [7:0]        frames_dropped
);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PIXELS - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  bank_state_t       bank_state [2];
  logic              ready_en;
  logic              wr_bank;
  logic              rd_bank;
  logic [ADDR_W-1:0] wr_cnt;
  logic              frame_available;
  logic              xfer;
  logic              at_end;
  logic              frame_done;
  logic              frame_bad;
  logic              release_req;
  logic              wdata_unused;

  // ready_en holds pix_ready low while reset is asserted
  assign pix_ready   = ready_en & (bank_state[wr_bank] != BANK_FULL);
  assign xfer        = pix_valid & pix_ready;
  assign at_end      = (wr_cnt == LAST_IDX);
  assign frame_done  = xfer & at_end & pix_last;
  assign frame_bad   = xfer & (pix_last ^ at_end);
  assign release_req = classifier_input_valid_write_en &
                       ~classifier_input_valid_write_data[0] & frame_available;
  assign wdata_unused = ^classifier_input_valid_write_data[7:1];

  assign classifier_input_valid_read_data = {7'b0, frame_available};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_en        <= 1'b0;
      bank_state[0]   <= BANK_EMPTY;
      bank_state[1]   <= BANK_EMPTY;
      wr_bank         <= 1'b0;
      rd_bank         <= 1'b0;
      wr_cnt          <= '0;
      frame_available <= 1'b0;
      frame_err       <= 1'b0;
      frames_dropped  <= 8'd0;
    end else begin
      ready_en <= 1'b1;
      // release and producer never target the same bank: the producer is stalled on a FULL bank
      for (int b = 0; b < 2; b++) begin
        if (release_req && rd_bank == 1'(b)) begin
          bank_state[b] <= BANK_EMPTY;
        end else if (xfer && wr_bank == 1'(b)) begin
          if (frame_done)     bank_state[b] <= BANK_FULL;
          else if (frame_bad) bank_state[b] <= BANK_EMPTY;
          else                bank_state[b] <= BANK_FILLING;
        end
      end
      if (xfer) wr_cnt <= (frame_done | frame_bad) ? '0 : wr_cnt + 1'b1;
      if (frame_done) wr_bank <= ~wr_bank;
      if (frame_bad) begin
        frame_err      <= 1'b1;
        frames_dropped <= sat_inc(frames_dropped);
      end
      if (release_req) rd_bank <= ~rd_bank;
      // forced low for one cycle on release so the classifier cannot release twice
      frame_available <= release_req ? 1'b0 : (bank_state[rd_bank] == BANK_FULL);
    end
  end

  logic              addr_oob;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  bank_q_p1 [2];
  logic              rd_bank_p1;
  logic              rd_zero_p1;

  assign addr_oob = (classifier_input_address_a >= ADDR_W'(PIXELS));
  assign rd_addr  = addr_oob ? '0 : classifier_input_address_a;

  for (genvar g = 0; g < 2; g++) begin : g_bank
    frame_bank_ram #(
      .PIXELS(PIXELS),
      .PIX_W (PIX_W),
      .ADDR_W(ADDR_W)
    ) u_ram (
      .clk       (clk),
      .wr_en     (xfer && (wr_bank == 1'(g))),
      .wr_addr   (wr_cnt),
      .wr_data   (pix_data),
      .rd_addr   (rd_addr),
      .rd_data_p1(bank_q_p1[g])
    );
  end

  // p1: bank select and out-of-range flag captured alongside the RAM read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_bank_p1 <= 1'b0;
      rd_zero_p1 <= 1'b1;
    end else begin
      rd_bank_p1 <= rd_bank;
      rd_zero_p1 <= addr_oob;
    end
  end

  assign classifier_input_read_data_a = rd_zero_p1 ? '0 :
                                        {{(RD_W - PIX_W){1'b0}}, bank_q_p1[rd_bank_p1]};
endmodule

// File: tb/tb_classifier_frame_loader.sv
// Randomized bench for classifier_frame_loader against a frame-FIFO reference model.
module tb_classifier_frame_loader;
  import classifier_pkg::*;

  localparam int NPIX = CLS_PIXELS;
  localparam int TMO  = 5000;

  logic        clk;
  logic        reset;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_last;
  logic        pix_ready;
  logic [7:0]  classifier_input_valid_read_data;
  logic        classifier_input_valid_write_en;
  logic [7:0]  classifier_input_valid_write_data;
  logic [9:0]  classifier_input_address_a;
  logic [15:0] classifier_input_read_data_a;
  logic        frame_err;
  logic [7:0]  frames_dropped;
  logic        fa;

  int total = 0;
  int bad   = 0;

  // reference model: completed, unreleased frames in order, as a flat pixel queue
  logic [7:0] pq[$];
  int held     = 0;
  int dropped  = 0;
  int consumed = 0;
  int fa_rises = 0;
  logic fa_q   = 1'b0;

  assign fa = classifier_input_valid_read_data[0];

  classifier_frame_loader dut (
    .clk                              (clk),
    .reset                            (reset),
    .pix_data                         (pix_data),
    .pix_valid                        (pix_valid),
    .pix_last                         (pix_last),
    .pix_ready                        (pix_ready),
    .classifier_input_valid_read_data (classifier_input_valid_read_data),
    .classifier_input_valid_write_en  (classifier_input_valid_write_en),
    .classifier_input_valid_write_data(classifier_input_valid_write_data),
    .classifier_input_address_a       (classifier_input_address_a),
    .classifier_input_read_data_a     (classifier_input_read_data_a),
    .frame_err                        (frame_err),
    .frames_dropped                   (frames_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fa && !fa_q) fa_rises++;
    fa_q = fa;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, pix_ready, 0);
    chk({tag, "_rdata"}, classifier_input_read_data_a, 0);
    chk({tag, "_valid"}, classifier_input_valid_read_data, 0);
    chk({tag, "_err"}, frame_err, 0);
    chk({tag, "_drop"}, frames_dropped, 0);
  endtask

  // mode 0 clean, 1 early last at pixel 500, 2 no last at pixel 783, 3 stop after 300 pixels
  task automatic send_frame(input int k, input int mode, input bit rnd, input bit rel_at_end);
    logic [7:0] px [NPIX];
    int  n;
    int  guard;
    bit  last;
    bit  fin;
    n = (mode == 1) ? 501 : (mode == 3) ? 300 : NPIX;
    for (int i = 0; i < n; i++) begin
      fin   = rel_at_end && (i == n - 1);
      px[i] = rnd ? 8'($urandom) : 8'((k * 7 + i) & 8'hFF);
      last  = (mode == 0 && i == NPIX - 1) || (mode == 1 && i == 500);
      if (!fin && $urandom_range(0, 3) == 0) tick();
      pix_data  = px[i];
      pix_last  = last;
      pix_valid = 1'b1;
      guard = 0;
      while (!pix_ready && guard < TMO) begin
        tick();
        guard++;
      end
      if (!pix_ready) begin
        chk("px_ready_timeout", pix_ready, 1);
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        return;
      end
      if (fin) begin
        classifier_input_valid_write_en   = 1'b1;
        classifier_input_valid_write_data = 8'($urandom) & 8'hFE;
      end
      tick();
      pix_valid = 1'b0;
      pix_last  = 1'b0;
      if (fin) begin
        classifier_input_valid_write_en = 1'b0;
        held--;
      end
    end
    if (mode == 0) begin
      for (int i = 0; i < NPIX; i++) pq.push_back(px[i]);
      held++;
    end
    if (mode == 1 || mode == 2) dropped = (dropped < 255) ? dropped + 1 : 255;
  endtask

  task automatic release_frame();
    classifier_input_valid_write_en   = 1'b1;
    classifier_input_valid_write_data = 8'($urandom) & 8'hFE;
    tick();
    classifier_input_valid_write_en = 1'b0;
    held--;
    chk("fa_drop", fa, 0);
  endtask

  task automatic read_frame(input bit do_release);
    int guard = 0;
    logic [7:0] e;
    while (!fa && guard < TMO) begin
      tick();
      guard++;
    end
    chk("fa_wait", classifier_input_valid_read_data, 8'h01);
    if (!fa) return;
    chk("model_depth", pq.size() >= NPIX, 1);
    if (pq.size() < NPIX) return;
    consumed++;
    classifier_input_address_a = 10'd0;
    for (int a = 0; a < NPIX; a++) begin
      tick();
      e = pq.pop_front();
      chk("rd_px", classifier_input_read_data_a, {8'h00, e});
      if (a < NPIX - 1) classifier_input_address_a = 10'(a + 1);
    end
    if (do_release) release_frame();
  endtask

  initial begin
    int g;
    pix_data  = 8'd0;
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    classifier_input_valid_write_en   = 1'b0;
    classifier_input_valid_write_data = 8'd0;
    classifier_input_address_a        = 10'd0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    chk_reset("rst0");
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("ready_after_rst", pix_ready, 1);

    // 10 frames streamed while the classifier model consumes them
    fa_rises = 0;
    fork
      for (int k = 0; k < 10; k++) send_frame(k, 0, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) read_frame(1'b1);
    join
    chk("t1_frames", consumed, 10);
    chk("t1_fa_rises", fa_rises, 10);
    chk("t1_dropped", frames_dropped, 0);
    chk("t1_fa_idle", fa, 0);

    // both banks full, third frame back-pressured until one release
    consumed = 0;
    fork
      begin
        send_frame(0, 0, 1'b1, 1'b0);
        send_frame(0, 0, 1'b1, 1'b0);
        send_frame(0, 0, 1'b1, 1'b0);
      end
      begin
        g = 0;
        while (held < 2 && g < TMO) begin
          tick();
          g++;
        end
        repeat (20) tick();
        chk("t2_held", held, 2);
        chk("t2_stall_ready", pix_ready, (held < 2) ? 1 : 0);
        chk("t2_fa", fa, 1);
        read_frame(1'b0);
        chk("t2_still_stalled", pix_ready, 0);
        release_frame();
        chk("t2_ready_rel", pix_ready, 1);
        read_frame(1'b1);
        read_frame(1'b1);
      end
    join
    chk("t2_frames", consumed, 3);
    chk("t2_dropped", frames_dropped, 0);

    // framing errors
    send_frame(0, 1, 1'b1, 1'b0);
    chk("t3_err", frame_err, 1);
    chk("t3_drop1", frames_dropped, dropped);
    chk("t3_fa", fa, (held > 0) ? 1 : 0);
    send_frame(0, 0, 1'b1, 1'b0);
    read_frame(1'b1);
    send_frame(0, 2, 1'b1, 1'b0);
    chk("t3_drop2", frames_dropped, dropped);
    chk("t3_fa2", fa, 0);
    chk("t3_ready", pix_ready, 1);

    // release on the edge the other bank completes
    send_frame(0, 0, 1'b1, 1'b0);
    read_frame(1'b0);
    chk("t4_fa_pre", fa, 1);
    send_frame(0, 0, 1'b1, 1'b1);
    chk("t4_fa_low", fa, 0);
    classifier_input_address_a = 10'd0;
    tick();
    chk("t4_fa_high", fa, 1);
    chk("t4_rd0", classifier_input_read_data_a, {8'h00, pq[0]});

    // out-of-range addresses and a non-release write
    classifier_input_address_a = 10'd784;
    tick();
    chk("t5_a784", classifier_input_read_data_a, 0);
    classifier_input_address_a = 10'd1023;
    tick();
    chk("t5_a1023", classifier_input_read_data_a, 0);
    classifier_input_valid_write_en   = 1'b1;
    classifier_input_valid_write_data = 8'h01;
    tick();
    classifier_input_valid_write_en = 1'b0;
    chk("t5_fa_hold", fa, 1);
    classifier_input_address_a = 10'd0;
    tick();
    chk("t5_rd_same", classifier_input_read_data_a, {8'h00, pq[0]});
    chk("t5_ready", pix_ready, (held < 2) ? 1 : 0);
    read_frame(1'b1);

    // reset mid-frame
    send_frame(0, 3, 1'b1, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk_reset("t6");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();
    held    = 0;
    dropped = 0;
    pq.delete();
    send_frame(0, 0, 1'b1, 1'b0);
    read_frame(1'b1);
    chk("t6_dropped", frames_dropped, dropped);
    chk("t6_err", frame_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
